button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Consumes the clean, synchronized level produced by the button conditioning stage.
- Turns that level into single-cycle user-interface events: press, release, single click, double click, long press, and auto-repeat while held.
- Sits between the button conditioning stage and the control FSMs, so no downstream logic times button gestures itself.

Parameters:
LONG_CYCLES, 50000000, cycles held continuously (counted from the press event) before long_o fires; minimum 2
REPEAT_CYCLES, 10000000, period between repeat_o pulses after long_o; minimum 2
DCLICK_CYCLES, 12500000, max cycles from release to second press that still counts as a double click; minimum 2
CTR_W, 26, timer width; must satisfy 2**CTR_W > max(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
btn  in  1  conditioned button level, already synchronous to clk, 1 = pressed
press_o  out  1  one-cycle pulse on every press
release_o  out  1  one-cycle pulse on every release
click_o  out  1  one-cycle pulse: short press not followed by a second press within DCLICK_CYCLES
dclick_o  out  1  one-cycle pulse on the second press of a double click
long_o  out  1  one-cycle pulse when a hold reaches LONG_CYCLES
repeat_o  out  1  one-cycle pulse every REPEAT_CYCLES after long_o while still held
held_o  out  1  registered copy of the button level

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While in reset: all outputs are 0, state = IDLE, timer = 0, btn_q = 0, init = 1.
- All outputs are registered.
- Event latency: an event pulse is high for exactly the one cycle following the clk edge that samples the edge condition.

First edge after reset:
- Loads btn_q <= btn and clears init.
- Emits no event. A button held through reset produces no press.
- If btn was 1 at that edge, state goes to HOLD with the timer stopped, so no long or repeat fires for that hold. The eventual release pulses release_o and returns to IDLE.

Edge detection:
- rise = btn & ~btn_q
- fall = ~btn & btn_q
- press_o <= rise; release_o <= fall, in every state.
- held_o <= btn.

Timer:
- CTR_W bits; cleared on every state entry; increments by 1 each cycle in PRESS, HOLD and GAP.
- Never wraps, because a threshold compare always clears it first.

States: IDLE, PRESS, HOLD, GAP. Flag second marks a press that already produced dclick_o.

Transitions:
- IDLE, rise -> PRESS; second = 0.
- PRESS, fall -> if second = 1: IDLE. Else: GAP.
- PRESS, timer == LONG_CYCLES-1, no fall -> long_o; go HOLD.
- HOLD, timer == REPEAT_CYCLES-1 -> repeat_o; timer cleared; stay.
- HOLD, fall -> IDLE. No click after a long press.
- GAP, rise -> dclick_o (same cycle as press_o); go PRESS; second = 1.
- GAP, timer == DCLICK_CYCLES-1, no rise -> click_o; go IDLE.

Simultaneous events:
- Fall on the edge where the long threshold hits: release wins. No long_o; the press is treated as short.
- Rise on the edge where GAP expires: the rise wins, giving dclick_o and no click_o.
- fall in HOLD on a repeat-threshold edge: no repeat_o.

Other rules:
- A triple press is a double click followed by a fresh press sequence.
- Reset asserted mid-gesture aborts it with no pending click/dclick emitted. Outputs clear immediately, asynchronously.
- Events are mutually exclusive except these pairs:
  - press_o with dclick_o
  - release_o alone

Decomposition:
- Shared package button_pkg holds:
  - the state enum (IDLE, PRESS, HOLD, GAP), 2 bits
  - default timing constants in cycles for a 100 MHz clk
- Natural sub-module: gesture_timer, a clearable up-counter with terminal-count compare against a run-time limit input. A single instance is shared by all states; the FSM muxes in the limit.
- Edge detection and the FSM stay in the top module.

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, DCLICK_CYCLES=6):
- Reset then btn=1 for 3 cycles, then 0 -> press_o 1 cycle after rise; release_o 1 cycle after fall; click_o exactly 6 cycles after release_o; no long_o.
- btn=1 for 20 cycles -> press_o; long_o 8 cycles after press_o; repeat_o at +4 and +8 after long_o; on release, release_o only, no click_o.
- Press 2 cycles, release, re-press after 3 cycles -> dclick_o coincident with the second press_o; no click_o. After the second release, no click_o and the FSM is back in IDLE.
- Release and re-press on the same edge that GAP would expire (gap of exactly 6 cycles) -> dclick_o, no click_o; release landing on the long threshold edge -> click_o later, no long_o.
- btn held high through rst_n deassert -> no press_o, no long_o; a later release gives release_o only. rst_n asserted mid-GAP -> all outputs 0 at once, no click_o after reset.
- Three short presses 2 cycles apart -> press, dclick, press, then click_o 6 cycles after the third release.

Source files
------------

// File: rtl/button_pkg.sv
// Shared state encoding and default 100 MHz timing for the button event decoder.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // 0.5 s long press, 0.1 s repeat period, 125 ms double-click window at 100 MHz
  localparam int unsigned DEF_LONG_CYCLES   = 32'd50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd10_000_000;
  localparam int unsigned DEF_DCLICK_CYCLES = 32'd12_500_000;
  localparam int unsigned DEF_CTR_W         = 32'd26;

endpackage

// File: rtl/gesture_timer.sv
// Clearable up-counter shared by all gesture states; flags when the count
// reaches the terminal value supplied by the FSM.
module gesture_timer #(
  parameter int unsigned W = 32'd26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         hit_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over increment
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = en_i & (count_q == tc_i);

endmodule

// File: rtl/button_event_decoder.sv
// Turns the conditioned button level into single-cycle UI events:
// press, release, click, double click, long press and auto-repeat.
module button_event_decoder
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter int unsigned CTR_W         = DEF_CTR_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  state_e state_q, state_d;
  logic   btn_q, init_q;
  logic   second_q, second_d;
  logic   frozen_q, frozen_d;
  logic   press_q, press_d, release_q, release_d, click_q, click_d;
  logic   dclick_q, dclick_d, long_q, long_d, repeat_q, repeat_d;
  logic   held_q, held_d;
  logic   rise, fall;
  logic   tmr_clr, tmr_en, tmr_hit;
  logic [CTR_W-1:0] tmr_tc;

  // Terminal count and enable for the shared timer, selected by state
  always_comb begin
    tmr_tc = '0;
    tmr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_tc = '0;
        tmr_en = 1'b0;
      end
      ST_PRESS: begin
        tmr_tc = CTR_W'(LONG_CYCLES - 32'd1);
        tmr_en = 1'b1;
      end
      ST_HOLD: begin
        tmr_tc = CTR_W'(REPEAT_CYCLES - 32'd1);
        tmr_en = ~frozen_q;
      end
      ST_GAP: begin
        tmr_tc = CTR_W'(DCLICK_CYCLES - 32'd1);
        tmr_en = 1'b1;
      end
      default: begin
        tmr_tc = '0;
        tmr_en = 1'b0;
      end
    endcase
  end

  // Edge detection, gesture FSM next state and event pulses
  always_comb begin
    rise      = btn & ~btn_q;
    fall      = ~btn & btn_q;
    state_d   = state_q;
    second_d  = second_q;
    frozen_d  = frozen_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    dclick_d  = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = btn;
    if (init_q) begin
      // A button held through reset is tracked but never timed
      state_d  = btn ? ST_HOLD : ST_IDLE;
      frozen_d = btn;
      second_d = 1'b0;
    end else begin
      press_d   = rise;
      release_d = fall;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d  = ST_PRESS;
            second_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (fall) begin
            state_d = second_q ? ST_IDLE : ST_GAP;
          end else if (tmr_hit) begin
            long_d   = 1'b1;
            frozen_d = 1'b0;
            state_d  = ST_HOLD;
          end else begin
            state_d = ST_PRESS;
          end
        end
        ST_HOLD: begin
          if (fall) begin
            frozen_d = 1'b0;
            state_d  = ST_IDLE;
          end else if (tmr_hit) begin
            repeat_d = 1'b1;
            state_d  = ST_HOLD;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_GAP: begin
          if (rise) begin
            dclick_d = 1'b1;
            second_d = 1'b1;
            state_d  = ST_PRESS;
          end else if (tmr_hit) begin
            click_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    tmr_clr = (state_d != state_q) | repeat_d | (state_q == ST_IDLE);
  end

  gesture_timer #(
    .W (CTR_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_i  (tmr_tc),
    .hit_o (tmr_hit)
  );

  // State, edge history and registered event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      btn_q     <= 1'b0;
      init_q    <= 1'b1;
      second_q  <= 1'b0;
      frozen_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      dclick_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn;
      init_q    <= 1'b0;
      second_q  <= second_d;
      frozen_q  <= frozen_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      dclick_q  <= dclick_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign click_o   = click_q;
  assign dclick_o  = dclick_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign held_o    = held_q;

endmodule
